// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Operand scheduler for an N x N output-stationary systolic array. On an
//   accepted start it captures one A and one B matrix, pulses an accumulator
//   clear, then streams diagonally skewed rows of A into the west edge and
//   columns of B into the north edge, one wavefront per clock. After the
//   last wavefront it waits for the array to finish propagating and then
//   strobes done.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : job request, only looked at while idle
//   a_mat      : A matrix, A[i][k] at [(i*N+k)*W +: W]
//   b_mat      : B matrix, B[k][j] at [(k*N+j)*W +: W]
//   busy       : high from the clear cycle through the done cycle
//   clr_acc    : one-cycle accumulator clear to the array
//   a_out      : west-edge stream, row i at [i*W +: W]
//   b_out      : north-edge stream, column j at [j*W +: W]
//   feed_valid : high while wavefronts are being fed
//   done       : one-cycle pulse, array results are final
module systolic_feeder #(
  parameter int N         = 2,
  parameter int W         = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*N*W-1:0] a_mat,
  input  logic [N*N*W-1:0] b_mat,
  output logic             busy,
  output logic             clr_acc,
  output logic [N*W-1:0]   a_out,
  output logic [N*W-1:0]   b_out,
  output logic             feed_valid,
  output logic             done
);

  // The shared counter walks the wavefront index during feeding and the
  // settle cycles while draining, so it is sized for the longer of the two.
  localparam int MAXC = ((2*N-1) > DRAIN_CYC) ? (2*N-1) : DRAIN_CYC;
  localparam int CW   = $clog2(MAXC+1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2*N-2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC-1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      t;
  logic [CW-1:0]      t_nxt;
  logic               capture;
  logic [N*N*W-1:0]   a_reg;
  logic [N*N*W-1:0]   b_reg;

  logic               busy_nxt;
  logic               clr_nxt;
  logic               feed_nxt;
  logic               done_nxt;
  logic [N*W-1:0]     a_nxt;
  logic [N*W-1:0]     b_nxt;

  // State, counter, captured operands and all outputs live here. Outputs are
  // computed one cycle ahead from the next state so that every port comes
  // straight from a flop, and the async reset zeroes the streams at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      t          <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      busy       <= 1'b0;
      clr_acc    <= 1'b0;
      feed_valid <= 1'b0;
      done       <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
    end else begin
      state      <= state_nxt;
      t          <= t_nxt;
      if (capture) begin
        a_reg <= a_mat;
        b_reg <= b_mat;
      end
      busy       <= busy_nxt;
      clr_acc    <= clr_nxt;
      feed_valid <= feed_nxt;
      done       <= done_nxt;
      a_out      <= a_nxt;
      b_out      <= b_nxt;
    end
  end

  // Sequencing: a start seen while idle captures the operands and launches
  // the job; once running, start is ignored until the machine is idle again,
  // which leaves one idle cycle between jobs when start is held high.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        t_nxt = '0;
        if (start) begin
          state_nxt = CLEAR;
          capture   = 1'b1;
        end
      end
      CLEAR: begin
        state_nxt = FEED;
        t_nxt     = '0;
      end
      FEED: begin
        if (t == FEED_LAST) begin
          state_nxt = DRAIN;
          t_nxt     = '0;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      DRAIN: begin
        if (t == DRAIN_LAST) begin
          state_nxt = DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  // Output values for the coming cycle. During a wavefront t, row i of the
  // west edge carries A[i][k] and column i of the north edge carries B[k][i]
  // wherever i+k == t; every slot off that anti-diagonal is driven to zero
  // so the array accumulates nothing from it.
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    clr_nxt  = (state_nxt == CLEAR);
    feed_nxt = (state_nxt == FEED);
    done_nxt = (state_nxt == DONE);
    a_nxt    = '0;
    b_nxt    = '0;
    if (state_nxt == FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_nxt) == (i + k)) begin
            a_nxt[i*W +: W] = a_reg[(i*N+k)*W +: W];
            b_nxt[i*W +: W] = b_reg[(k*N+i)*W +: W];
          end
        end
      end
    end
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Operand scheduler that drives the west (A) and north (B) edges of the N x N output-stationary systolic array.
- Latches one N x N A matrix and one N x N B matrix on a start handshake.
- Emits diagonally skewed row/column streams, one wavefront per clock.
- Pulses a clear before feeding and a done strobe once the array's result outputs are final.
- Sits between the operand buffers and the array; its a_out/b_out buses map directly onto the array's a1..aN / b1..bN inputs.

Parameters:
N, 2, array dimension (rows = columns = inner dimension)
W, 16, operand width in bits
DRAIN_CYC, 2, cycles waited after the last feed cycle before done (must be >= N for the array's propagation latency)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
a_mat  input  N*N*W  A matrix; element A[i][k] at bits [(i*N+k)*W +: W]
b_mat  input  N*N*W  B matrix; element B[k][j] at bits [(k*N+j)*W +: W]
busy  output  1  high from CLEAR through DONE inclusive
clr_acc  output  1  one-cycle accumulator clear to the array
a_out  output  N*W  west-edge stream; row i at [i*W +: W]
b_out  output  N*W  north-edge stream; column j at [j*W +: W]
feed_valid  output  1  high during FEED cycles
done  output  1  one-cycle pulse; array results valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, t=0, matrix registers=0, and every output is 0 (busy, clr_acc, a_out, b_out, feed_valid, done).
- All outputs are registered. No combinational path from start or the matrices to any output.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 at an edge: capture a_mat/b_mat, go to CLEAR.
  - start=0: stay in IDLE.
- CLEAR: one cycle. clr_acc=1, busy=1, a_out=b_out=0. Next state FEED with t=0.
- FEED: lasts 2N-1 cycles, t = 0..2N-2. feed_valid=1.
  - a_out row i = A[i][t-i] if 0 <= t-i < N, else 0.
  - b_out column j = B[t-j][j] if 0 <= t-j < N, else 0.
  - At t=2N-2, go to DRAIN with the counter reloaded to 0.
- DRAIN: lasts DRAIN_CYC cycles. a_out=b_out=0, feed_valid=0. Then go to DONE.
- DONE: one cycle. done=1, busy=1. Next state IDLE, with busy=0 in the following cycle.
- Latency (start sampled at edge k):
  - clr_acc high in cycle k+1.
  - Feed cycles k+2 .. k+2N.
  - done high in cycle k+2N+1+DRAIN_CYC.
- Input stability: captured matrices are immune to later changes on a_mat/b_mat until the next accepted start.
- start while busy: ignored; no re-capture, no queueing.
- start held high continuously: a new job begins on the edge after the cycle where busy returns to 0, i.e. one idle cycle between jobs.
- rst asserted mid-operation: immediate return to reset values, with the streams zeroed asynchronously. No done pulse is emitted for the aborted job.
- Counter width: ceil(log2(max(2N-1, DRAIN_CYC)+1)) bits. No arithmetic on data; operands pass through unmodified.

Test Plan:
1. Reset: rst=1 with random a_mat/b_mat and start=1 -> all outputs stay 0. After release with start=0, busy stays 0 indefinitely.
2. Basic job, N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulsed at edge k:
   - cycle k+1: clr_acc=1.
   - k+2: a_out={row0=1,row1=0}, b_out={col0=5,col1=0}.
   - k+3: a={2,3}, b={7,6}.
   - k+4: a={0,4}, b={0,8}.
   - done at k+7.
   - With the array attached, C = [[19,22],[43,50]].
3. Busy rejection: pulse start again at k+3 with different matrices -> no effect. Streams and done timing are identical to scenario 2.
4. Back-to-back: start held high across two jobs -> second clr_acc appears exactly 2 cycles after the first done. The second job uses matrices sampled at its own acceptance edge.
5. Abort: assert rst during FEED t=1 -> a_out/b_out/busy/feed_valid drop to 0 without waiting for a clock edge, and no done is pulsed. A fresh start then completes normally with correct C.
6. Edge values, A=B=all 16'hFFFF -> streams carry 16'hFFFF unmodified in the diagonal slots and 0 in the off-diagonal slots.
